// File: rtl/ibi_rx_handler.sv
// Controller-side IBI receiver: header ACK/NACK against the device table, payload capture, STOP, status.
// Optional build macro IBI_RX_TIMESTAMP_EN adds a free-running timestamp captured at each accepted start.
module ibi_rx_handler #(
   parameter int NUM_DEVS       = 8,
   parameter int MAX_DATA_BYTES = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  ibi_start_i,
   input  logic                  bus_stop_i,
   output logic                  scl_run_o,
   output logic                  stop_req_o,
   input  logic                  stop_done_i,
   input  logic [NUM_DEVS-1:0]   dev_valid_i,
   input  logic [7*NUM_DEVS-1:0] dev_addr_i,
   input  logic [NUM_DEVS-1:0]   dev_ibi_accept_i,
   input  logic [NUM_DEVS-1:0]   dev_ibi_payload_i,
   output logic                  bus_rx_req_byte_o,
   output logic                  bus_rx_req_bit_o,
   input  logic                  bus_rx_done_i,
   input  logic [7:0]            bus_rx_req_value_i,
   output logic                  bus_tx_req_bit_o,
   output logic [7:0]            bus_tx_req_value_o,
   output logic                  bus_tx_sel_od_pp_o,
   input  logic                  bus_tx_done_i,
   output logic                  ibi_byte_valid_o,
   input  logic                  ibi_byte_ready_i,
   output logic [7:0]            ibi_byte_o,
   output logic                  ibi_byte_last_o,
   output logic                  ibi_status_valid_o,
   output logic [2:0]            ibi_status_o,
   output logic [6:0]            ibi_addr_o,
   output logic [7:0]            ibi_len_o,
   output logic [31:0]           ibi_timestamp_o
);

   localparam logic [8:0] MAX_B = 9'(MAX_DATA_BYTES);

   typedef enum logic [3:0] {
      S_IDLE, S_RECV_ADDR, S_DECIDE, S_DRIVE_ACK, S_RECV_DATA,
      S_RECV_TBIT, S_PUSH, S_REQ_STOP, S_WAIT_STOP, S_REPORT
   } state_e;

   state_e      state_q, state_d;
   logic [6:0]  addr_q, addr_d;
   logic        rnw_q, rnw_d, ack_q, ack_d, pay_q, pay_d;
   logic [7:0]  data_q, data_d;
   logic        tbit_q, tbit_d, last_q, last_d;
   logic [7:0]  rcv_q, rcv_d, len_q, len_d;
   logic [2:0]  status_q, status_d;
   logic        bvalid_q, bvalid_d, blast_q, blast_d;
   logic [7:0]  bdata_q, bdata_d;
   logic        scl_q, scl_d, stopreq_q, stopreq_d, stv_q, stv_d;
   logic        match, match_pay, start_acc, bus_err, hs, at_max;

   // Iterate downwards so the lowest matching index is the one left standing.
   always_comb begin
      match     = 1'b0;
      match_pay = 1'b0;
      for (int k = NUM_DEVS - 1; k >= 0; k--) begin
         if (dev_valid_i[k] && dev_ibi_accept_i[k] && (dev_addr_i[7*k +: 7] == addr_q)) begin
            match     = 1'b1;
            match_pay = dev_ibi_payload_i[k];
         end
      end
   end

   assign start_acc = (state_q == S_IDLE) && ibi_start_i && enable_i;
   assign bus_err   = bus_stop_i && (state_q inside {S_RECV_ADDR, S_DECIDE, S_DRIVE_ACK,
                                                     S_RECV_DATA, S_RECV_TBIT, S_PUSH});
   assign hs        = bvalid_q && ibi_byte_ready_i;
   assign at_max    = ({1'b0, rcv_q} + 9'd1) == MAX_B;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rnw_d    = rnw_q;
      ack_d    = ack_q;
      pay_d    = pay_q;
      data_d   = data_q;
      tbit_d   = tbit_q;
      last_d   = last_q;
      rcv_d    = rcv_q;
      len_d    = len_q + {7'd0, hs};
      status_d = status_q;
      bvalid_d = hs ? 1'b0 : bvalid_q;
      bdata_d  = bdata_q;
      blast_d  = blast_q;
      if (bus_err) begin
         state_d  = S_REPORT;
         status_d = 3'd4;
      end else begin
         case (state_q)
            S_IDLE: if (start_acc) begin
               state_d  = S_RECV_ADDR;
               len_d    = 8'd0;
               rcv_d    = 8'd0;
               status_d = 3'd0;
            end
            S_RECV_ADDR: if (bus_rx_done_i) begin
               addr_d  = bus_rx_req_value_i[7:1];
               rnw_d   = bus_rx_req_value_i[0];
               state_d = S_DECIDE;
            end
            S_DECIDE: begin
               ack_d   = rnw_q && match;
               pay_d   = match_pay;
               state_d = S_DRIVE_ACK;
            end
            S_DRIVE_ACK: if (bus_tx_done_i) begin
               if (!ack_q) begin
                  status_d = 3'd1;
                  state_d  = S_REQ_STOP;
               end else if (pay_q) begin
                  state_d = S_RECV_DATA;
               end else begin
                  status_d = 3'd0;
                  state_d  = S_REQ_STOP;
               end
            end
            S_RECV_DATA: if (bus_rx_done_i) begin
               // Previous byte still unaccepted after a full byte time: close it out, drop the new one.
               if (bvalid_q && !ibi_byte_ready_i) begin
                  blast_d  = 1'b1;
                  status_d = 3'd2;
                  state_d  = S_REQ_STOP;
               end else begin
                  data_d  = bus_rx_req_value_i;
                  state_d = S_RECV_TBIT;
               end
            end
            S_RECV_TBIT: if (bus_rx_done_i) begin
               tbit_d  = bus_rx_req_value_i[0];
               last_d  = !bus_rx_req_value_i[0] || at_max;
               state_d = S_PUSH;
            end
            S_PUSH: begin
               bvalid_d = 1'b1;
               bdata_d  = data_q;
               blast_d  = last_q;
               rcv_d    = rcv_q + 8'd1;
               if (last_q) begin
                  status_d = tbit_q ? 3'd3 : 3'd0;
                  state_d  = S_REQ_STOP;
               end else begin
                  state_d = S_RECV_DATA;
               end
            end
            S_REQ_STOP:  state_d = S_WAIT_STOP;
            S_WAIT_STOP: if (stop_done_i) state_d = S_REPORT;
            S_REPORT:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
      scl_d     = state_d inside {S_RECV_ADDR, S_DECIDE, S_DRIVE_ACK, S_RECV_DATA, S_RECV_TBIT, S_PUSH};
      stopreq_d = state_d inside {S_REQ_STOP, S_WAIT_STOP};
      stv_d     = (state_d == S_REPORT);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rnw_q     <= 1'b0;
         ack_q     <= 1'b0;
         pay_q     <= 1'b0;
         data_q    <= '0;
         tbit_q    <= 1'b0;
         last_q    <= 1'b0;
         rcv_q     <= '0;
         len_q     <= '0;
         status_q  <= '0;
         bvalid_q  <= 1'b0;
         bdata_q   <= '0;
         blast_q   <= 1'b0;
         scl_q     <= 1'b0;
         stopreq_q <= 1'b0;
         stv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rnw_q     <= rnw_d;
         ack_q     <= ack_d;
         pay_q     <= pay_d;
         data_q    <= data_d;
         tbit_q    <= tbit_d;
         last_q    <= last_d;
         rcv_q     <= rcv_d;
         len_q     <= len_d;
         status_q  <= status_d;
         bvalid_q  <= bvalid_d;
         bdata_q   <= bdata_d;
         blast_q   <= blast_d;
         scl_q     <= scl_d;
         stopreq_q <= stopreq_d;
         stv_q     <= stv_d;
      end
   end

   assign bus_rx_req_byte_o  = (state_q == S_RECV_ADDR) || (state_q == S_RECV_DATA);
   assign bus_rx_req_bit_o   = (state_q == S_RECV_TBIT);
   assign bus_tx_req_bit_o   = (state_q == S_DRIVE_ACK);
   assign bus_tx_req_value_o = {7'd0, (state_q == S_DRIVE_ACK) && !ack_q};
   assign bus_tx_sel_od_pp_o = 1'b0;

   assign scl_run_o          = scl_q;
   assign stop_req_o         = stopreq_q;
   assign ibi_byte_valid_o   = bvalid_q;
   assign ibi_byte_o         = bdata_q;
   assign ibi_byte_last_o    = blast_q;
   assign ibi_status_valid_o = stv_q;
   assign ibi_status_o       = status_q;
   assign ibi_addr_o         = addr_q;
   assign ibi_len_o          = len_q;

`ifdef IBI_RX_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_cnt_q <= '0;
         ts_q     <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         if (start_acc) ts_q <= ts_cnt_q;
      end
   end

   assign ibi_timestamp_o = ts_q;
`else
   assign ibi_timestamp_o = '0;
`endif

endmodule

// File: tb/tb_ibi_rx_handler.sv
// Self-checking bench for ibi_rx_handler: table-driven IBIs plus hand-written corner sequences,
// with a bus/target responder and scoreboard queues for ACK bits, payload bytes and status.
module tb_ibi_rx_handler;

   localparam int NDEV = 8;
   localparam int MAXB = 2;
   localparam int LAT  = 2;

   logic              clk, rst_i, enable_i, ibi_start_i, bus_stop_i;
   logic              scl_run_o, stop_req_o, stop_done_i;
   logic [NDEV-1:0]   dev_valid_i, dev_ibi_accept_i, dev_ibi_payload_i;
   logic [7*NDEV-1:0] dev_addr_i;
   logic              bus_rx_req_byte_o, bus_rx_req_bit_o, bus_rx_done_i;
   logic [7:0]        bus_rx_req_value_i;
   logic              bus_tx_req_bit_o, bus_tx_sel_od_pp_o, bus_tx_done_i;
   logic [7:0]        bus_tx_req_value_o;
   logic              ibi_byte_valid_o, ibi_byte_ready_i, ibi_byte_last_o;
   logic [7:0]        ibi_byte_o;
   logic              ibi_status_valid_o;
   logic [2:0]        ibi_status_o;
   logic [6:0]        ibi_addr_o;
   logic [7:0]        ibi_len_o;
   logic [31:0]       ibi_timestamp_o;

   ibi_rx_handler #(.NUM_DEVS(NDEV), .MAX_DATA_BYTES(MAXB)) dut (
      .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .ibi_start_i(ibi_start_i),
      .bus_stop_i(bus_stop_i), .scl_run_o(scl_run_o), .stop_req_o(stop_req_o),
      .stop_done_i(stop_done_i), .dev_valid_i(dev_valid_i), .dev_addr_i(dev_addr_i),
      .dev_ibi_accept_i(dev_ibi_accept_i), .dev_ibi_payload_i(dev_ibi_payload_i),
      .bus_rx_req_byte_o(bus_rx_req_byte_o), .bus_rx_req_bit_o(bus_rx_req_bit_o),
      .bus_rx_done_i(bus_rx_done_i), .bus_rx_req_value_i(bus_rx_req_value_i),
      .bus_tx_req_bit_o(bus_tx_req_bit_o), .bus_tx_req_value_o(bus_tx_req_value_o),
      .bus_tx_sel_od_pp_o(bus_tx_sel_od_pp_o), .bus_tx_done_i(bus_tx_done_i),
      .ibi_byte_valid_o(ibi_byte_valid_o), .ibi_byte_ready_i(ibi_byte_ready_i),
      .ibi_byte_o(ibi_byte_o), .ibi_byte_last_o(ibi_byte_last_o),
      .ibi_status_valid_o(ibi_status_valid_o), .ibi_status_o(ibi_status_o),
      .ibi_addr_o(ibi_addr_o), .ibi_len_o(ibi_len_o), .ibi_timestamp_o(ibi_timestamp_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  hdr;
      int          n;
      logic [23:0] bytes;
      logic [2:0]  tb;
      bit          ack;
      logic [2:0]  st;
      logic [7:0]  len;
      logic [6:0]  addr;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         st_cnt = 0;
   logic [7:0] rxq[$];
   bit         ackq[$];
   logic [8:0] expq[$];
   logic [2:0] stq[$];
   bit         ready_mode = 1'b1;
   bit         stop_seen = 1'b0;
   bit         valid_seen = 1'b0;
   int         rx_wait = 0, tx_wait = 0, sp_wait = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Target/bus responder plus output monitors, all on the falling edge.
   initial begin
      bus_rx_done_i = 1'b0; bus_tx_done_i = 1'b0; stop_done_i = 1'b0;
      bus_rx_req_value_i = 8'h00; ibi_byte_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         bus_rx_done_i = 1'b0; bus_tx_done_i = 1'b0; stop_done_i = 1'b0;
         ibi_byte_ready_i = ready_mode;
         if (rst_i) begin
            rx_wait = 0; tx_wait = 0; sp_wait = 0;
         end else begin
            if (bus_rx_req_byte_o || bus_rx_req_bit_o) begin
               if (rx_wait < LAT) rx_wait++;
               else if (rxq.size() > 0) begin
                  rx_wait = 0;
                  bus_rx_done_i = 1'b1;
                  bus_rx_req_value_i = rxq.pop_front();
               end
            end else rx_wait = 0;
            if (bus_tx_req_bit_o) begin
               if (tx_wait < LAT) tx_wait++;
               else begin
                  tx_wait = 0;
                  bus_tx_done_i = 1'b1;
                  check("ack_open_drain", bus_tx_sel_od_pp_o, 0);
                  if (ackq.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL ack_unexpected: got %0h, expected none", bus_tx_req_value_o);
                  end else check("ack_value", bus_tx_req_value_o, {7'd0, ackq.pop_front()});
               end
            end else tx_wait = 0;
            if (stop_req_o) begin
               stop_seen = 1'b1;
               if (sp_wait < LAT) sp_wait++;
               else begin
                  sp_wait = 0;
                  stop_done_i = 1'b1;
               end
            end else sp_wait = 0;
         end
         if (ibi_byte_valid_o) valid_seen = 1'b1;
         if (ibi_byte_valid_o && ibi_byte_ready_i) begin
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL byte_unexpected: got %0h, expected none", {ibi_byte_last_o, ibi_byte_o});
            end else check("byte", {ibi_byte_last_o, ibi_byte_o}, expq.pop_front());
         end
         if (ibi_status_valid_o) begin
            st_cnt++;
            if (stq.size() == 0) begin
               checks++; errors++;
               $display("FAIL status_unexpected: got %0d, expected none", ibi_status_o);
            end else check("status", ibi_status_o, stq.pop_front());
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      ibi_start_i = 1'b1;
      @(negedge clk);
      ibi_start_i = 1'b0;
      check("start_to_rxreq", bus_rx_req_byte_o, 1);
   endtask

   task automatic wait_status(input int prev);
      for (int c = 0; c < 300; c++) begin
         if (st_cnt != prev) break;
         @(negedge clk);
      end
      check("status_arrived", st_cnt != prev, 1);
   endtask

   task automatic run_row(input vec_t v);
      int  prev;
      bit  last;
      rxq.delete();
      rxq.push_back(v.hdr);
      for (int i = 0; i < v.n; i++) begin
         rxq.push_back(v.bytes[8*i +: 8]);
         rxq.push_back({7'd0, v.tb[i]});
      end
      ackq.push_back(!v.ack);
      if (v.ack) begin
         for (int i = 0; i < v.n; i++) begin
            last = !v.tb[i] || (i + 1 == MAXB);
            expq.push_back({last, v.bytes[8*i +: 8]});
            if (last) break;
         end
      end
      stq.push_back(v.st);
      stop_seen = 1'b0; valid_seen = 1'b0;
      prev = st_cnt;
      pulse_start();
      wait_status(prev);
      repeat (4) @(negedge clk);
      check("addr", ibi_addr_o, v.addr);
      check("len", ibi_len_o, v.len);
      check("status_held", ibi_status_o, v.st);
      check("stop_requested", stop_seen, 1);
      check("bytes_all_delivered", expq.size(), 0);
      check("byte_valid_seen", valid_seen, v.len != 0);
   endtask

   vec_t tv[8];
   int   prev;
   logic [31:0] ts1, ts2;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{hdr:8'h43, n:2, bytes:24'h003CA5, tb:3'b001, ack:1, st:3'd0, len:8'd2, addr:7'h21};
      tv[1] = '{hdr:8'h45, n:0, bytes:24'h0,      tb:3'b000, ack:0, st:3'd1, len:8'd0, addr:7'h22};
      tv[2] = '{hdr:8'h43, n:3, bytes:24'h332211, tb:3'b111, ack:1, st:3'd3, len:8'd2, addr:7'h21};
      tv[3] = '{hdr:8'h61, n:0, bytes:24'h0,      tb:3'b000, ack:1, st:3'd0, len:8'd0, addr:7'h30};
      tv[4] = '{hdr:8'h63, n:0, bytes:24'h0,      tb:3'b000, ack:0, st:3'd1, len:8'd0, addr:7'h31};
      tv[5] = '{hdr:8'h65, n:0, bytes:24'h0,      tb:3'b000, ack:0, st:3'd1, len:8'd0, addr:7'h32};
      tv[6] = '{hdr:8'h42, n:0, bytes:24'h0,      tb:3'b000, ack:0, st:3'd1, len:8'd0, addr:7'h21};
      tv[7] = '{hdr:8'h81, n:1, bytes:24'h00005A, tb:3'b000, ack:1, st:3'd0, len:8'd1, addr:7'h40};

      // Device table: entries 1 and 2 share 0x30 (lowest wins, no payload); 3 refuses; 4 invalid.
      dev_addr_i = '0;
      dev_addr_i[0*7 +: 7] = 7'h21; dev_addr_i[1*7 +: 7] = 7'h30;
      dev_addr_i[2*7 +: 7] = 7'h30; dev_addr_i[3*7 +: 7] = 7'h31;
      dev_addr_i[4*7 +: 7] = 7'h32; dev_addr_i[5*7 +: 7] = 7'h40;
      dev_valid_i       = 8'b0010_1111;
      dev_ibi_accept_i  = 8'b0011_0111;
      dev_ibi_payload_i = 8'b0011_1101;

      rst_i = 1'b1; enable_i = 1'b1; ibi_start_i = 1'b0; bus_stop_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check("reset_ctrl_outs", {scl_run_o, stop_req_o, bus_rx_req_byte_o, bus_rx_req_bit_o,
                                bus_tx_req_bit_o, bus_tx_req_value_o, ibi_byte_valid_o,
                                ibi_status_valid_o}, 0);
      check("reset_data_outs", {ibi_byte_o, ibi_byte_last_o, ibi_status_o, ibi_addr_o, ibi_len_o}, 0);
      check("reset_timestamp", ibi_timestamp_o, 0);

      for (int r = 0; r < 8; r++) run_row(tv[r]);

      // Overflow: consumer stalls across two bytes.
      ready_mode = 1'b0;
      rxq.delete();
      rxq.push_back(8'h43); rxq.push_back(8'h77); rxq.push_back(8'h01);
      rxq.push_back(8'h88); rxq.push_back(8'h01);
      ackq.push_back(1'b0); expq.push_back({1'b1, 8'h77}); stq.push_back(3'd2);
      prev = st_cnt;
      pulse_start();
      wait_status(prev);
      @(negedge clk);
      check("ovf_byte_held", {ibi_byte_valid_o, ibi_byte_last_o, ibi_byte_o}, {2'b11, 8'h77});
      check("ovf_len_before_ready", ibi_len_o, 0);
      ready_mode = 1'b1;
      repeat (4) @(negedge clk);
      check("ovf_len", ibi_len_o, 1);
      check("ovf_delivered", expq.size(), 0);

      // Bus STOP in RecvData after one byte was pushed.
      rxq.delete();
      rxq.push_back(8'h43); rxq.push_back(8'h5A); rxq.push_back(8'h01);
      ackq.push_back(1'b0); expq.push_back({1'b0, 8'h5A}); stq.push_back(3'd4);
      stop_seen = 1'b0;
      prev = st_cnt;
      pulse_start();
      for (int c = 0; c < 200; c++) begin
         if (expq.size() == 0 && bus_rx_req_byte_o) break;
         @(negedge clk);
      end
      check("berr_reached_recvdata", bus_rx_req_byte_o, 1);
      bus_stop_i = 1'b1;
      @(negedge clk);
      bus_stop_i = 1'b0;
      wait_status(prev);
      repeat (3) @(negedge clk);
      check("berr_len", ibi_len_o, 1);
      check("berr_no_stop_req", stop_seen, 0);
      check("berr_scl_off", scl_run_o, 0);

      // Bus STOP while waiting for a T-bit: the pending byte is discarded.
      rxq.delete();
      rxq.push_back(8'h43); rxq.push_back(8'h99);
      ackq.push_back(1'b0); stq.push_back(3'd4);
      stop_seen = 1'b0; valid_seen = 1'b0;
      prev = st_cnt;
      pulse_start();
      for (int c = 0; c < 200; c++) begin
         if (bus_rx_req_bit_o) break;
         @(negedge clk);
      end
      check("discard_reached_tbit", bus_rx_req_bit_o, 1);
      bus_stop_i = 1'b1;
      @(negedge clk);
      bus_stop_i = 1'b0;
      wait_status(prev);
      repeat (3) @(negedge clk);
      check("discard_len", ibi_len_o, 0);
      check("discard_no_byte", valid_seen, 0);
      check("discard_no_stop_req", stop_seen, 0);

      // Start ignored while disabled.
      enable_i = 1'b0;
      @(negedge clk); ibi_start_i = 1'b1;
      @(negedge clk); ibi_start_i = 1'b0;
      check("disabled_no_rxreq", {bus_rx_req_byte_o, scl_run_o}, 0);
      enable_i = 1'b1;

      // Synchronous reset in the middle of an IBI.
      rxq.delete();
      stop_seen = 1'b0;
      prev = st_cnt;
      pulse_start();
      repeat (3) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("midrst_idle", {bus_rx_req_byte_o, scl_run_o, stop_req_o}, 0);
      check("midrst_addr", ibi_addr_o, 0);
      repeat (10) @(negedge clk);
      check("midrst_no_status", st_cnt, prev);
      check("midrst_no_stop", stop_seen, 0);

      // Two IBIs started exactly 100 cycles apart.
      rxq.delete();
      rxq.push_back(8'h45); rxq.push_back(8'h45);
      ackq.push_back(1'b1); ackq.push_back(1'b1);
      stq.push_back(3'd1); stq.push_back(3'd1);
      prev = st_cnt;
      @(negedge clk); ibi_start_i = 1'b1;
      @(negedge clk); ibi_start_i = 1'b0;
      repeat (50) @(negedge clk);
      ts1 = ibi_timestamp_o;
      repeat (49) @(negedge clk);
      ibi_start_i = 1'b1;
      @(negedge clk); ibi_start_i = 1'b0;
      wait_status(prev + 1);
      repeat (3) @(negedge clk);
      ts2 = ibi_timestamp_o;
      check("ts_two_reports", st_cnt, prev + 2);
`ifdef IBI_RX_TIMESTAMP_EN
      check("ts_delta", ts2 - ts1, 100);
`else
      check("ts_tied_zero", {ts1, ts2}, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
